// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: HD44780 4-bit-mode init sequencer and command/data byte writer
// ACLK/ARESET clock and async active-high reset; cmd_valid/cmd_ready/cmd_rs/cmd_data byte input;
// init_done sticky init flag; busy activity flag; lcd_rs/lcd_rw/lcd_e/lcd_db LCD pins.
// Define LCD_FIFO_EN for a 4-entry command FIFO instead of a single holding register.
module lcd_cmd_sequencer #(
  parameter int SETUP_CYC     = 2,
  parameter int E_PULSE_CYC   = 25,
  parameter int HOLD_CYC      = 2,
  parameter int CMD_WAIT_CYC  = 4000,
  parameter int CLR_WAIT_CYC  = 164000,
  parameter int INIT_WAIT_CYC = 410000,
  parameter int PWR_WAIT_CYC  = 1500000,
  parameter int CNT_W         = 21
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_db
);
  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SETUP, PULSE, HOLD, XWAIT} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] timer;
  logic [2:0] init_idx;
  logic [8:0] head, src;
  logic [7:0] init_byte;
  logic [3:0] db_q;
  logic tmr_done, nib_only, lo, clr, push, pop, q_empty, more, rs_q;
  int dur;
  assign push = cmd_valid & cmd_ready;
  // the queue head stays in place while its byte is on the bus and is released when its wait ends
  assign pop = (state == XWAIT) & tmr_done & init_done;
`ifdef LCD_FIFO_EN
  logic [8:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  assign cmd_ready = init_done & ((count != 3'd4) | pop);
  assign q_empty = count == 3'd0;
  assign more = count > 3'd1;
  // at the end of a wait, look past the entry being released so the next byte starts without a gap
  assign head = mem[(state == XWAIT) ? rd_ptr + 2'd1 : rd_ptr];
  always_ff @(posedge ACLK)
    if (push) mem[wr_ptr] <= {cmd_rs, cmd_data};
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, pop};
    end
`else
  logic [8:0] hold;
  logic pending;
  assign cmd_ready = init_done & (state == IDLE) & !pending;
  assign q_empty = !pending;
  assign more = 1'b0;
  assign head = hold;
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      pending <= 1'b0;
      hold <= '0;
    end else if (push) begin
      pending <= 1'b1;
      hold <= {cmd_rs, cmd_data};
    end else if (pop) pending <= 1'b0;
`endif
  always_comb begin
    init_byte = (init_idx < 3'd3) ? 8'h30 : (init_idx == 3'd3) ? 8'h20 : (init_idx == 3'd4) ? 8'h28 :
                (init_idx == 3'd5) ? 8'h0C : (init_idx == 3'd6) ? 8'h06 : 8'h01;
    src = init_done ? head : {1'b0, init_byte};
    nib_only = !init_done & (init_idx < 3'd4);
    clr = !src[8] & (src[7:2] == 6'd0);
    // power-up wait counts up from the reset value of zero; every other state counts down
    tmr_done = (state == PWR_WAIT) ? (timer == CNT_W'(PWR_WAIT_CYC - 1)) : (timer == '0);
  end
  assign dur = (state_n == SETUP) ? SETUP_CYC : (state_n == PULSE) ? E_PULSE_CYC :
               (state_n == HOLD) ? HOLD_CYC :
               (state_n == XWAIT) ? (nib_only ? INIT_WAIT_CYC : clr ? CLR_WAIT_CYC : CMD_WAIT_CYC) : 1;
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) state <= PWR_WAIT;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      PWR_WAIT: if (tmr_done) state_n = INIT;
      INIT:     state_n = SETUP;
      IDLE:     if (!q_empty) state_n = SETUP;
      SETUP:    if (tmr_done) state_n = PULSE;
      PULSE:    if (tmr_done) state_n = HOLD;
      HOLD:     if (tmr_done) state_n = (!lo && !nib_only) ? SETUP : XWAIT;
      XWAIT:    if (tmr_done) state_n = init_done ? (more ? SETUP : IDLE) : (init_idx == 3'd7) ? IDLE : INIT;
      default:  state_n = PWR_WAIT;
    endcase
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      timer <= '0;
      init_idx <= '0;
      init_done <= 1'b0;
      lo <= 1'b0;
      rs_q <= 1'b0;
      db_q <= '0;
    end else begin
      timer <= (state_n != state) ? CNT_W'(dur - 1) : (state == PWR_WAIT) ? timer + CNT_W'(1) :
               (timer != '0) ? timer - CNT_W'(1) : timer;
      if (state == HOLD && tmr_done) lo <= state_n == SETUP;
      if (state_n == SETUP && state != SETUP) begin
        rs_q <= src[8];
        db_q <= (state == HOLD) ? src[3:0] : src[7:4];
      end
      if (state == XWAIT && tmr_done && !init_done) begin
        init_idx <= init_idx + 3'd1;
        init_done <= init_idx == 3'd7;
      end
    end
  always_comb begin
    lcd_e = state == PULSE;
    lcd_rw = 1'b0;
    lcd_rs = rs_q;
    lcd_db = db_q;
    busy = (state != IDLE) | !q_empty;
  end
endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: scoreboard bench for the LCD command sequencer
module tb_lcd_cmd_sequencer;
  localparam int SU = 2, EP = 3, HO = 2, CW = 10, LW = 30, IW = 20, PW = 50;
`ifdef LCD_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif
  logic ACLK = 1'b0, ARESET = 1'b0, cmd_valid = 1'b0, cmd_rs = 1'b0;
  logic [7:0] cmd_data = '0;
  logic cmd_ready, init_done, busy, lcd_rs, lcd_rw, lcd_e;
  logic [3:0] lcd_db;
  lcd_cmd_sequencer #(.SETUP_CYC(SU), .E_PULSE_CYC(EP), .HOLD_CYC(HO), .CMD_WAIT_CYC(CW),
    .CLR_WAIT_CYC(LW), .INIT_WAIT_CYC(IW), .PWR_WAIT_CYC(PW), .CNT_W(21)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rs(cmd_rs),
    .cmd_data(cmd_data), .init_done(init_done), .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_db(lcd_db));
  always #5 ACLK = ~ACLK;
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;
  typedef struct {logic rs; logic [3:0] db; int gap; int acc;} nib_t;
  nib_t nq[$];
  int rq[$];
  int total = 0, bad = 0, last_acc = 0;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // reference: a byte is two nibble strobes, high first; clear/home (rs=0, value below 4) waits longest
  function automatic void exp_byte(input logic rs, input logic [7:0] d, input int acc, input bit rd);
    nq.push_back('{rs, d[7:4], 0, acc});
    nq.push_back('{rs, d[3:0], HO + SU, -1});
    if (rd && !FIFO) rq.push_back(HO + ((!rs && d < 8'd4) ? LW : CW));
  endfunction
  function automatic void exp_init();
    nq.delete();
    rq.delete();
    for (int i = 0; i < 3; i++) nq.push_back('{1'b0, 4'h3, 0, -1});
    nq.push_back('{1'b0, 4'h2, 0, -1});
    exp_byte(1'b0, 8'h28, -1, 1'b0);
    exp_byte(1'b0, 8'h0C, -1, 1'b0);
    exp_byte(1'b0, 8'h06, -1, 1'b0);
    exp_byte(1'b0, 8'h01, -1, 1'b1);
  endfunction
  task automatic send(input logic rs, input logic [7:0] d, input bit lat);
    int i;
    cmd_rs = rs;
    cmd_data = d;
    cmd_valid = 1'b1;
    for (i = 0; i < 3000 && !cmd_ready; i++) begin
      @(posedge ACLK);
      #2;
    end
    chk("accept_wait", cmd_ready, 1);
    last_acc = cyc + 1;
    if (cmd_ready) exp_byte(rs, d, lat ? last_acc : -1, 1'b1);
    @(posedge ACLK);
    #2;
    cmd_valid = 1'b0;
  endtask
  nib_t n;
  logic pe = 1'b0, pr = 1'b0, pi = 1'b0, pb = 1'b1;
  int hi = 0, fall = 0, rel = 0, irise = 0, bfall = 0;
  bit first = 1'b1;
  always @(negedge ACLK) begin
    if (ARESET) begin
      pe = 1'b0; pr = 1'b0; pi = 1'b0; pb = 1'b1; hi = 0; first = 1'b1; rel = cyc;
    end else begin
      if (lcd_e && !pe) begin
        if (first) chk("pwr_wait", int'(cyc - rel >= PW + SU), 1);
        first = 1'b0;
        chk("e_expected", int'(nq.size() > 0), 1);
        if (nq.size() > 0) begin
          n = nq.pop_front();
          chk("lcd_rs", lcd_rs, n.rs);
          chk("lcd_db", lcd_db, n.db);
          chk("lcd_rw", lcd_rw, 0);
          if (n.gap > 0) chk("nib_gap", cyc - fall, n.gap);
          if (n.acc >= 0) chk("latency", cyc - n.acc, SU + 1);
        end
      end
      if (lcd_e) hi++;
      if (!lcd_e && pe) begin
        chk("e_width", hi, EP);
        hi = 0;
        fall = cyc;
      end
      if (init_done && !pi) irise = cyc;
      if (!busy && pb) bfall = cyc;
`ifndef LCD_FIFO_EN
      if (cmd_ready && !pr) begin
        chk("ready_expected", int'(rq.size() > 0), 1);
        if (rq.size() > 0) chk("xwait", cyc - fall, rq.pop_front());
        chk("busy_idle", busy, 0);
        chk("init_done_ready", init_done, 1);
      end
`endif
      pe = lcd_e; pr = cmd_ready; pi = init_done; pb = busy;
    end
  end
  initial begin
    exp_init();
    #1 ARESET = 1'b1;
    #1;
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_db", lcd_db, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy", busy, 1);
    cmd_rs = 1'b1;
    cmd_data = 8'h5A;
    cmd_valid = 1'b1;
    repeat (3) @(posedge ACLK);
    #2 ARESET = 1'b0;
    send(1'b1, 8'h5A, !FIFO);
    chk("first_accept", last_acc - irise, 1);
    send(1'b1, 8'h41, !FIFO);
    send(1'b0, 8'h01, !FIFO);
    send(1'b0, 8'h80, !FIFO);
    send(1'b1, 8'h01, !FIFO);
    for (int k = 0; k < 20; k++)
      send(1'($urandom_range(0, 1)), $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom), !FIFO);
    for (int i = 0; i < 3000 && busy; i++) begin @(posedge ACLK); #2; end
    send(1'b1, 8'h7E, 1'b1);
    for (int i = 0; i < 100 && !lcd_e; i++) begin @(posedge ACLK); #2; end
    chk("e_seen", lcd_e, 1);
    ARESET = 1'b1;
    #1;
    chk("mid_rst_e", lcd_e, 0);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_busy", busy, 1);
    exp_init();
    repeat (2) @(posedge ACLK);
    #2 ARESET = 1'b0;
    send(1'b0, 8'h0C, !FIFO);
    for (int i = 0; i < 3000 && busy; i++) begin @(posedge ACLK); #2; end
`ifdef LCD_FIFO_EN
    send(1'b0, 8'h80, 1'b1);
    send(1'b1, 8'h31, 1'b0);
    send(1'b0, 8'h01, 1'b0);
    send(1'b1, 8'h55, 1'b0);
    chk("fifo_full", cmd_ready, 0);
    send(1'b1, 8'h2A, 1'b0);
`else
    send(1'b1, 8'h2A, 1'b1);
`endif
    for (int i = 0; i < 3000 && (nq.size() > 0 || rq.size() > 0); i++) begin @(posedge ACLK); #2; end
    chk("sb_drain", nq.size() + rq.size(), 0);
    for (int i = 0; i < 500 && busy; i++) begin @(posedge ACLK); #2; end
    chk("busy_end", busy, 0);
    chk("busy_fall", bfall - fall, HO + CW);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
